// File: rtl/proc_sequencer_pkg.sv
// proc_sequencer_pkg: opcodes, field positions and state encoding shared with the processor
package proc_sequencer_pkg;
    localparam logic [2:0] MV   = 3'b000;
    localparam logic [2:0] MVI  = 3'b001;
    localparam logic [2:0] ADD  = 3'b010;
    localparam logic [2:0] SUB  = 3'b011;
    localparam logic [2:0] ADDI = 3'b100;
    localparam logic [2:0] SUBI = 3'b101;
    localparam logic [2:0] HALT = 3'b111;

    localparam int OP_LSB = 6;
    localparam int X_LSB  = 3;
    localparam int Y_LSB  = 0;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_IMM, S_WAIT, S_HALT} state_t;

    function automatic logic [2:0] opcode(input logic [8:0] w);
        return w[OP_LSB +: 3];
    endfunction

    function automatic logic [2:0] fld_x(input logic [8:0] w);
        return w[X_LSB +: 3];
    endfunction

    function automatic logic [2:0] fld_y(input logic [8:0] w);
        return w[Y_LSB +: 3];
    endfunction

    function automatic logic is_immediate(input logic [2:0] op);
        return op == MVI || op == ADDI || op == SUBI;
    endfunction
endpackage

// File: rtl/proc_sequencer_prog_mem.sv
// prog_mem: DEPTH x 9 program store, registered write, two combinational read ports
module prog_mem #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [8:0]    wdata,
    input  logic [AW-1:0] raddr_a,
    output logic [8:0]    rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [8:0]    rdata_b
);
    logic [8:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];
endmodule

// File: rtl/proc_sequencer.sv
// proc_sequencer: feeds the nine-bit processor over DIN/Run/Done from a loadable program memory
module proc_sequencer
    import proc_sequencer_pkg::*;
#(
    parameter int DEPTH   = 32,
    parameter int AW      = 5,
    parameter int TIMEOUT = 7
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          Start,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [8:0]    prog_data,
    input  logic          Done,
    output logic [8:0]    DIN,
    output logic          Run,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          halted,
    output logic          err,
    output logic [7:0]    retired
);
    localparam int WW = $clog2(TIMEOUT + 1);

    state_t state, state_d;
    logic [AW-1:0] pc_d;
    logic [WW-1:0] wdog, wdog_d;
    logic [7:0] retired_d;
    logic halted_d, err_d;
    logic [8:0] instr, imm;
    logic [2:0] op;

    assign busy = state inside {S_ISSUE, S_IMM, S_WAIT};
    assign op   = opcode(instr);

    prog_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk(Clock),
        .we(prog_we && !busy),
        .waddr(prog_addr),
        .wdata(prog_data),
        .raddr_a(pc),
        .rdata_a(instr),
        .raddr_b(pc + AW'(1)),
        .rdata_b(imm)
    );

    always_ff @(posedge Clock or negedge Resetn)
        if (!Resetn) begin
            state   <= S_IDLE;
            pc      <= '0;
            wdog    <= '0;
            retired <= '0;
            halted  <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_d;
            pc      <= pc_d;
            wdog    <= wdog_d;
            retired <= retired_d;
            halted  <= halted_d;
            err     <= err_d;
        end

    // Done is checked before the watchdog so a completion on the last allowed cycle still counts
    always_comb begin
        state_d   = state;
        pc_d      = pc;
        wdog_d    = wdog;
        retired_d = retired;
        halted_d  = halted;
        err_d     = err;
        Run       = 1'b0;
        DIN       = '0;
        case (state)
            S_IDLE, S_HALT:
                if (Start) begin
                    state_d   = S_ISSUE;
                    pc_d      = '0;
                    retired_d = '0;
                    halted_d  = 1'b0;
                    err_d     = 1'b0;
                end
            S_ISSUE:
                if (op == HALT) begin
                    halted_d = 1'b1;
                    state_d  = S_HALT;
                end else begin
                    Run     = 1'b1;
                    DIN     = instr;
                    wdog_d  = '0;
                    state_d = is_immediate(op) ? S_IMM : S_WAIT;
                end
            S_IMM, S_WAIT: begin
                DIN = (state == S_IMM) ? imm : '0;
                if (Done) begin
                    pc_d      = pc + ((state == S_IMM) ? AW'(2) : AW'(1));
                    retired_d = retired + {7'd0, retired != 8'hFF};
                    state_d   = S_ISSUE;
                end else if (wdog == WW'(TIMEOUT - 1)) begin
                    err_d    = 1'b1;
                    halted_d = 1'b1;
                    state_d  = S_HALT;
                end else begin
                    wdog_d = wdog + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_proc_sequencer.sv
// tb_proc_sequencer: directed program runs against a small behavioural model of the nine-bit processor
module tb_proc_sequencer;
    import proc_sequencer_pkg::*;

    localparam int DEPTH = 32;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, prog_we = 1'b0, done, done_en = 1'b1;
    logic [4:0] prog_addr = '0, pc;
    logic [8:0] prog_data = '0, din;
    logic run, busy, halted, err;
    logic [7:0] retired;
    logic [8:0] ir;
    logic [8:0] r [8];
    logic [2:0] t;
    int n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    proc_sequencer dut (
        .Clock(clk), .Resetn(rst_n), .Start(start), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data), .Done(done),
        .DIN(din), .Run(run), .pc(pc), .busy(busy), .halted(halted),
        .err(err), .retired(retired)
    );

    // processor: Done one cycle after issue for mv/mvi, three for the ALU ops
    always_comb done = done_en && t != 3'd0 &&
                       t == ((opcode(ir) inside {ADD, SUB, ADDI, SUBI}) ? 3'd3 : 3'd1);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t  <= '0;
            ir <= '0;
            for (int i = 0; i < 8; i++) r[i] <= '0;
        end else if (run) begin
            ir <= din;
            t  <= 3'd1;
        end else if (done) begin
            t <= '0;
            case (opcode(ir))
                MV:   r[fld_x(ir)] <= r[fld_y(ir)];
                MVI:  r[fld_x(ir)] <= din;
                ADD:  r[fld_x(ir)] <= r[fld_x(ir)] + r[fld_y(ir)];
                SUB:  r[fld_x(ir)] <= r[fld_x(ir)] - r[fld_y(ir)];
                ADDI: r[fld_x(ir)] <= r[fld_x(ir)] + din;
                SUBI: r[fld_x(ir)] <= r[fld_x(ir)] - din;
                default: ;
            endcase
        end else if (t != 3'd0 && t != 3'd7) begin
            t <= t + 3'd1;
        end
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [8:0] d);
        prog_we = 1'b1;
        prog_addr = a;
        prog_data = d;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_halt(input string tag);
        for (int i = 0; i < 200 && !halted; i++) tick();
        check(tag, halted, 1'b1);
    endtask

    task automatic wait_issue(input logic [4:0] a, input string tag);
        for (int i = 0; i < 800 && !(run && pc == a); i++) tick();
        check(tag, run && pc == a, 1'b1);
    endtask

    initial begin
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_run", run, 1'b0);
        check("rst_din", din, 9'h000);
        check("rst_pc", pc, 5'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_retired", retired, 8'd0);

        wr(5'd0, 9'h040); wr(5'd1, 9'd5); wr(5'd2, 9'h1C0);
        go();
        check("mvi_run", run, 1'b1);
        check("mvi_din", din, 9'h040);
        tick();
        check("mvi_imm", din, 9'd5);
        check("mvi_run_once", run, 1'b0);
        tick();
        wait_halt("mvi_halt");
        check("mvi_pc", pc, 5'd2);
        check("mvi_retired", retired, 8'd1);
        check("mvi_r0", r[0], 9'd5);

        wr(5'd2, 9'h100); wr(5'd3, 9'd3); wr(5'd4, 9'h1C0);
        go();
        tick();
        tick();
        check("addi_run", run, 1'b1);
        check("addi_din", din, 9'h100);
        tick(); tick(); tick();
        check("addi_wait_pc", pc, 5'd2);
        tick();
        check("addi_done_pc", pc, 5'd4);
        check("addi_retired", retired, 8'd2);
        wait_halt("addi_halt");
        check("addi_r0", r[0], 9'd8);

        wr(5'd1, 9'd7); wr(5'd2, 9'h008); wr(5'd3, 9'h011); wr(5'd4, 9'h1C0);
        go();
        tick();
        tick();
        check("mv_din", din, 9'h008);
        tick();
        check("mv_wait_run", run, 1'b0);
        check("mv_wait_din", din, 9'h000);
        tick();
        check("mv_next_run", run, 1'b1);
        check("mv_next_din", din, 9'h011);
        wait_halt("mv_halt");
        check("mv_r1", r[1], 9'd7);
        check("mv_r2", r[2], 9'd7);
        check("mv_retired", retired, 8'd3);

        done_en = 1'b0;
        wr(5'd0, 9'h010);
        go();
        check("to_run", run, 1'b1);
        repeat (7) tick();
        check("to_err_early", err, 1'b0);
        check("to_busy", busy, 1'b1);
        tick();
        check("to_err", err, 1'b1);
        check("to_halted", halted, 1'b1);
        check("to_pc", pc, 5'd0);
        check("to_retired", retired, 8'd0);
        done_en = 1'b1;

        wr(5'd0, 9'd9);
        for (int a = 1; a < DEPTH - 1; a++) wr(5'(a), 9'h012);
        wr(5'(DEPTH - 1), 9'h040);
        go();
        wait_issue(5'(DEPTH - 1), "wrap_reach");
        check("wrap_din", din, 9'h040);
        prog_we = 1'b1; prog_addr = 5'd2; prog_data = 9'h1C0;
        tick();
        check("wrap_imm", din, 9'd9);
        tick();
        prog_we = 1'b0;
        check("wrap_pc", pc, 5'd1);
        wait_issue(5'd2, "lock_reach");
        check("lock_din", din, 9'h012);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_start_pc", pc, 5'd2);
        check("wrap_r0", r[0], 9'd9);
        repeat (600) tick();
        check("sat_retired", retired, 8'hFF);

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        wr(5'd0, 9'h040); wr(5'd1, 9'd4); wr(5'd2, 9'h088); wr(5'd3, 9'h1C0);
        go();
        wait_issue(5'd2, "add_reach");
        check("add_din", din, 9'h088);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_run", run, 1'b0);
        check("mid_rst_din", din, 9'h000);
        check("mid_rst_pc", pc, 5'd0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_retired", retired, 8'd0);
        tick();
        rst_n = 1'b1;
        go();
        wait_halt("retain_halt");
        check("retain_pc", pc, 5'd3);
        check("retain_retired", retired, 8'd2);
        check("retain_r1", r[1], 9'd4);

        prog_we = 1'b1; prog_addr = 5'd0; prog_data = 9'h1C0; start = 1'b1;
        tick();
        prog_we = 1'b0; start = 1'b0;
        check("sw_run", run, 1'b0);
        check("sw_retired", retired, 8'd0);
        tick();
        check("sw_halted", halted, 1'b1);
        check("sw_pc", pc, 5'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
